// File: rtl/messbauer_pkg.sv
// Shared types and helpers for the Mössbauer sweep generator: FSM state,
// channel alignment modes and the counter-width helper used by every block.
package messbauer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Channel pulse alignment relative to the start of each channel.
  localparam int CH_DELAYED = 0;
  localparam int CH_SYNC    = 1;

  // Bits needed for a counter that runs 0..value-1 (never less than one bit).
  function automatic int cnt_width(input int value);
    return (value <= 1) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/messbauer_pulse_stretcher.sv
// Registered pulse stretcher: a trigger sampled at an edge drives pulse high
// after that same edge for exactly WIDTH_CLKS clocks; a re-trigger restarts it.
module messbauer_pulse_stretcher
  import messbauer_pkg::*;
#(
  parameter int WIDTH_CLKS = 1
) (
  input  logic aclk,
  input  logic areset,
  input  logic trigger,
  output logic pulse
);

  localparam int CW = cnt_width(WIDTH_CLKS);
  localparam logic [CW-1:0] RELOAD = CW'(WIDTH_CLKS - 1);
  localparam logic [CW-1:0] ONE    = CW'(1);

  // Clocks still to hold after the current one.
  logic [CW-1:0] remaining;

  always_ff @(posedge aclk) begin
    if (areset) begin
      pulse     <= 1'b0;
      remaining <= '0;
    end else if (trigger) begin
      pulse     <= 1'b1;
      remaining <= RELOAD;
    end else if (remaining != '0) begin
      remaining <= remaining - ONE;
    end else begin
      pulse     <= 1'b0;
    end
  end

endmodule

// File: rtl/messbauer_sweep_generator.sv
// Velocity sweep timing master: one sweep of CHANNEL_NUMBER channels per start.
// Optional sweep completion counter is built when MESSBAUER_SWEEP_COUNTER_EN is defined.
module messbauer_sweep_generator
  import messbauer_pkg::*;
#(
  parameter int CHANNEL_NUMBER      = 512,
  parameter int CHANNEL_PERIOD_CLKS = 250,
  parameter int START_PULSE_CLKS    = 4,
  parameter int CHANNEL_PULSE_CLKS  = 2,
  parameter int CHANNEL_TYPE        = 0
) (
  input  logic                              aclk,
  input  logic                              areset,
  input  logic                              enable,
  output logic                              start,
  output logic                              channel,
  output logic [$clog2(CHANNEL_NUMBER)-1:0] channel_index,
  output logic                              half,
  output logic                              busy
`ifdef MESSBAUER_SWEEP_COUNTER_EN
  ,
  output logic                              sweep_done,
  output logic [31:0]                       sweep_count
`endif
);

  localparam int IW = $clog2(CHANNEL_NUMBER);
  localparam int PW = cnt_width(CHANNEL_PERIOD_CLKS);

  localparam logic [PW-1:0] LAST_PHASE = PW'(CHANNEL_PERIOD_CLKS - 1);
  localparam logic [IW-1:0] LAST_INDEX = IW'(CHANNEL_NUMBER - 1);
  localparam logic [IW-1:0] HALF_INDEX = IW'(CHANNEL_NUMBER / 2);

  // Phase at which the channel pulse begins, and the phase one clock earlier
  // when its trigger must be raised so the registered pulse lands on time.
  localparam int            CH_OFFSET = (CHANNEL_TYPE == CH_SYNC) ? 0 : START_PULSE_CLKS;
  localparam logic [PW-1:0] CH_PRE    = PW'((CH_OFFSET == 0) ? 0 : CH_OFFSET - 1);

  state_t         state;
  logic [PW-1:0]  phase;

  logic phase_wrap;
  logic last_channel;
  logic sweep_end;
  logic enter_sweep;
  logic enter_phase0;
  logic start_trig;
  logic channel_trig;

  always_comb begin
    phase_wrap   = (state == RUN) && (phase == LAST_PHASE);
    last_channel = (channel_index == LAST_INDEX);
    sweep_end    = phase_wrap && last_channel;
    enter_sweep  = enable && ((state == IDLE) || sweep_end);
    enter_phase0 = enter_sweep || (phase_wrap && !last_channel);
    start_trig   = enter_sweep;
    if (CH_OFFSET == 0) begin
      channel_trig = enter_phase0;
    end else begin
      channel_trig = (state == RUN) && (phase == CH_PRE);
    end
  end

  // enable is only consulted in IDLE and at the sweep-end edge, so a sweep
  // always runs to completion once started.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state         <= IDLE;
      phase         <= '0;
      channel_index <= '0;
      busy          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          phase         <= '0;
          channel_index <= '0;
          if (enable) begin
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (phase_wrap) begin
            phase <= '0;
            if (last_channel) begin
              channel_index <= '0;
              if (!enable) begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else begin
              channel_index <= channel_index + IW'(1);
            end
          end else begin
            phase <= phase + PW'(1);
          end
        end
        default: begin
          state         <= IDLE;
          phase         <= '0;
          channel_index <= '0;
          busy          <= 1'b0;
        end
      endcase
    end
  end

  assign half = (channel_index >= HALF_INDEX);

  messbauer_pulse_stretcher #(
    .WIDTH_CLKS (START_PULSE_CLKS)
  ) u_start_pulse (
    .aclk    (aclk),
    .areset  (areset),
    .trigger (start_trig),
    .pulse   (start)
  );

  messbauer_pulse_stretcher #(
    .WIDTH_CLKS (CHANNEL_PULSE_CLKS)
  ) u_channel_pulse (
    .aclk    (aclk),
    .areset  (areset),
    .trigger (channel_trig),
    .pulse   (channel)
  );

`ifdef MESSBAUER_SWEEP_COUNTER_EN
  // sweep_done is raised one edge early so it is high during the final
  // phase of the last channel; the count steps at the sweep-end edge.
  localparam logic [PW-1:0] PENULT_PHASE = PW'(CHANNEL_PERIOD_CLKS - 2);

  always_ff @(posedge aclk) begin
    if (areset) begin
      sweep_done  <= 1'b0;
      sweep_count <= '0;
    end else begin
      sweep_done <= (state == RUN) && last_channel && (phase == PENULT_PHASE);
      if (sweep_end) begin
        sweep_count <= sweep_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_messbauer_sweep_generator.sv
// Bench for messbauer_sweep_generator: two instances (synchronous and delayed
// channel alignment) driven in lockstep and compared against a sweep timeline model.
`timescale 1ns/1ps
module tb_messbauer_sweep_generator;
  import messbauer_pkg::*;

  localparam int N  = 4;
  localparam int P  = 8;
  localparam int S  = 2;
  localparam int C  = 1;
  localparam int IW = $clog2(N);

  typedef struct packed {
    logic          start;
    logic          ch_sync;
    logic          ch_del;
    logic [IW-1:0] idx;
    logic          half;
    logic          busy;
    logic          done;
    logic [31:0]   count;
  } exp_t;

  localparam int EW = $bits(exp_t);

  // ---------------- clock / reset ----------------
  logic aclk = 1'b0;
  logic areset;
  logic enable;
  always #5 aclk = ~aclk;

  logic          s_start, s_channel, s_half, s_busy;
  logic [IW-1:0] s_index;
  logic          d_start, d_channel, d_half, d_busy;
  logic [IW-1:0] d_index;
`ifdef MESSBAUER_SWEEP_COUNTER_EN
  logic          s_done, d_done;
  logic [31:0]   s_count, d_count;
`endif

  messbauer_sweep_generator #(
    .CHANNEL_NUMBER (N), .CHANNEL_PERIOD_CLKS (P), .START_PULSE_CLKS (S),
    .CHANNEL_PULSE_CLKS (C), .CHANNEL_TYPE (CH_SYNC)
  ) dut_sync (
    .aclk (aclk), .areset (areset), .enable (enable),
    .start (s_start), .channel (s_channel), .channel_index (s_index),
    .half (s_half), .busy (s_busy)
`ifdef MESSBAUER_SWEEP_COUNTER_EN
    , .sweep_done (s_done), .sweep_count (s_count)
`endif
  );

  messbauer_sweep_generator #(
    .CHANNEL_NUMBER (N), .CHANNEL_PERIOD_CLKS (P), .START_PULSE_CLKS (S),
    .CHANNEL_PULSE_CLKS (C), .CHANNEL_TYPE (CH_DELAYED)
  ) dut_del (
    .aclk (aclk), .areset (areset), .enable (enable),
    .start (d_start), .channel (d_channel), .channel_index (d_index),
    .half (d_half), .busy (d_busy)
`ifdef MESSBAUER_SWEEP_COUNTER_EN
    , .sweep_done (d_done), .sweep_count (d_count)
`endif
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  logic [EW-1:0] exp_q[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
  endtask

  // Timeline model: k = clocks since the current sweep's first edge, -1 when idle.
  int k      = -1;
  int n_done = 0;

  task automatic model_edge(input logic rst, input logic en);
    if (rst) begin
      k = -1;
      n_done = 0;
    end else if (k < 0) begin
      if (en) k = 0;
    end else if (k == N * P - 1) begin
      n_done++;
      k = en ? 0 : -1;
    end else begin
      k++;
    end
  endtask

  function automatic exp_t expect_now();
    exp_t e;
    int idx, ph;
    e = '0;
    e.count = 32'(n_done);
    if (k >= 0) begin
      idx       = k / P;
      ph        = k % P;
      e.busy    = 1'b1;
      e.idx     = IW'(idx);
      e.start   = (idx == 0) && (ph < S);
      e.ch_sync = (ph < C);
      e.ch_del  = (ph >= S) && (ph < S + C);
      e.half    = (idx >= N / 2);
      e.done    = (k == N * P - 1);
    end
    return e;
  endfunction

  // ---------------- driver ----------------
  task automatic drive_cycle(input logic rst, input logic en);
    exp_t e;
    areset = rst;
    enable = en;
    model_edge(rst, en);
    exp_q.push_back(expect_now());
    @(posedge aclk);
    #1;
    cyc++;
    if (exp_q.size() == 0) begin
      check_val("queue_empty", 32'd1, 32'd0);
    end else begin
      e = exp_t'(exp_q.pop_front());
      check_val("sync_start",   32'(s_start),   32'(e.start));
      check_val("sync_channel", 32'(s_channel), 32'(e.ch_sync));
      check_val("sync_index",   32'(s_index),   32'(e.idx));
      check_val("sync_half",    32'(s_half),    32'(e.half));
      check_val("sync_busy",    32'(s_busy),    32'(e.busy));
      check_val("del_start",    32'(d_start),   32'(e.start));
      check_val("del_channel",  32'(d_channel), 32'(e.ch_del));
      check_val("del_index",    32'(d_index),   32'(e.idx));
      check_val("del_busy",     32'(d_busy),    32'(e.busy));
`ifdef MESSBAUER_SWEEP_COUNTER_EN
      check_val("sync_done",    32'(s_done),    32'(e.done));
      check_val("sync_count",   s_count,        e.count);
      check_val("del_done",     32'(d_done),    32'(e.done));
      check_val("del_count",    d_count,        e.count);
`endif
    end
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] start_mask, sync_mask, del_mask, half_mask;

  initial begin
    areset = 1'b1;
    enable = 1'b0;

    repeat (3) drive_cycle(1'b1, 1'b1);
    repeat (3) drive_cycle(1'b0, 1'b0);

    // Three back-to-back sweeps; enable low only at the E+96 sweep-end edge.
    start_mask = '0; sync_mask = '0; del_mask = '0; half_mask = '0;
    for (int i = 0; i < 97; i++) begin
      drive_cycle(1'b0, i < 96);
      if (i < 32) begin
        start_mask[i] = s_start;
        sync_mask[i]  = s_channel;
        del_mask[i]   = d_channel;
        half_mask[i]  = s_half;
      end
      if (i == 32) begin
        check_val("restart_start", 32'(s_start), 32'd1);
        check_val("restart_index", 32'(s_index), 32'd0);
        check_val("restart_busy",  32'(s_busy),  32'd1);
      end
    end
    check_val("start_cycles",   start_mask, 32'h0000_0003);
    check_val("sync_ch_cycles", sync_mask,  32'h0101_0101);
    check_val("del_ch_cycles",  del_mask,   32'h0404_0404);
    check_val("half_cycles",    half_mask,  32'hFFFF_0000);
    repeat (3) drive_cycle(1'b0, 1'b0);

    // Enable dropped at E+5 and toggled mid-sweep; sweep still runs to E+32.
    for (int i = 0; i < 36; i++) begin
      drive_cycle(1'b0, (i < 5) || (i >= 10 && i < 13) || (i == 20));
      if (i == 31) check_val("late_sweep_busy", 32'(s_busy), 32'd1);
      if (i == 32) begin
        check_val("stop_busy",  32'(s_busy),  32'd0);
        check_val("stop_start", 32'(s_start), 32'd0);
      end
    end

    // Reset at E+13 with enable still high; start resumes at E+14.
    for (int i = 0; i < 20; i++) begin
      drive_cycle(i == 13, 1'b1);
      if (i == 13) check_val("rst_busy",  32'(s_busy),  32'd0);
      if (i == 14) check_val("rst_start", 32'(s_start), 32'd1);
    end
    drive_cycle(1'b1, 1'b0);

    // Random enable with rare resets.
    for (int i = 0; i < 400; i++) begin
      drive_cycle($urandom_range(0, 149) == 0, $urandom_range(0, 3) != 0);
    end
    repeat (40) drive_cycle(1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/messbauer_sweep_generator.md
# messbauer_sweep_generator

Parametrised successor to the Mössbauer start/channel generator. It produces one velocity sweep of `CHANNEL_NUMBER` equal-length channels per start pulse, with programmable channel period, pulse widths and start/channel alignment. It also exports the current channel index, the sweep half and a busy flag. It sits between the velocity drive front-end and the spectrum accumulator and acts as the timing master for channel-address generation.

## Interface
- `CHANNEL_NUMBER`, 512: channels per sweep, ≥ 2.
- `CHANNEL_PERIOD_CLKS`, 250: clocks per channel (P). Must exceed `START_PULSE_CLKS + CHANNEL_PULSE_CLKS`.
- `START_PULSE_CLKS`, 4: width of `start` in clocks, ≥ 1.
- `CHANNEL_PULSE_CLKS`, 2: width of `channel` in clocks, ≥ 1.
- `CHANNEL_TYPE`, 0: alignment mode.
  - 0: channel pulse is delayed by `START_PULSE_CLKS` within each channel.
  - 1: channel pulse starts at phase 0, synchronous with `start` on channel 0.

Ports:
- `aclk` in 1: sole clock; all logic is on its rising edge.
- `areset` in 1: synchronous, active-high reset.
- `enable` in 1: run request, level-sensitive.
- `start` out 1: sweep start pulse.
- `channel` out 1: per-channel pulse.
- `channel_index` out `$clog2(CHANNEL_NUMBER)`: current channel.
- `half` out 1: 1 while `channel_index ≥ CHANNEL_NUMBER/2`.
- `busy` out 1: 1 in state RUN.

## Operation
- FSM states: IDLE and RUN.
- IDLE → RUN at the first edge E with `enable`=1. The registered outputs after edge E are:
  - `busy`=1, `start`=1, `channel_index`=0, phase counter = 0.
- Phase counter:
  - Counts 0..P-1.
  - On wrap, `channel_index` increments.
  - After channel `CHANNEL_NUMBER-1`, `channel_index` wraps to 0.
- `start` is high for phases 0..`START_PULSE_CLKS`-1 of channel 0 only.
- `channel` is high for `CHANNEL_PULSE_CLKS` clocks in every channel, including channel 0. Its pulse begins at:
  - phase 0 when `CHANNEL_TYPE`=1;
  - phase `START_PULSE_CLKS` when `CHANNEL_TYPE`=0.
- Sweep end is the edge after phase P-1 of channel N-1:
  - `enable`=1 at that edge: the next sweep starts immediately, with no gap and `start` reasserted.
  - `enable`=0 at that edge: go to IDLE.
- Sweeps are never truncated:
  - Deasserting `enable` mid-sweep has no visible effect until sweep end.
  - Toggling `enable` within a sweep is ignored.
- `half` is derived combinationally from the registered `channel_index`.
- All counters are unsigned. The phase counter is `$clog2(CHANNEL_PERIOD_CLKS)` bits wide.

## Timing
- Reset values: `start`=0, `channel`=0, `channel_index`=0, `half`=0, `busy`=0. The FSM is in IDLE and all counters are 0.
- `areset` at any edge, including mid-sweep, overrides everything: outputs take reset values after that edge, and `enable` sampled at the same edge is ignored.
- Latency from `enable` to `start` is one edge; all outputs are registered except `half`.
- Channel k begins at edge E + k·P.
- Sweep length is exactly `CHANNEL_NUMBER`·P clocks.
- Back-to-back sweeps: the edge E + N·P is phase 0 of the next sweep.
- In IDLE, `busy`=0 and all pulses are 0; `channel_index` holds 0.

## Configuration
- `MESSBAUER_SWEEP_COUNTER_EN`, when defined, adds two outputs:
  - `sweep_done` (1 bit): a one-clock pulse on the last cycle of each completed sweep.
  - `sweep_count` (32 bits): increments on each completed sweep, wraps at 2^32, cleared by `areset`.
- Without the macro, both ports and their logic are absent and the remaining behaviour is identical.

## Structure
- Package `messbauer_pkg` holds:
  - the FSM state typedef (IDLE, RUN);
  - `CHANNEL_TYPE` constants (`CH_DELAYED`=0, `CH_SYNC`=1);
  - a shared function that computes counter widths.
- Sub-module `messbauer_pulse_stretcher`:
  - parameter `WIDTH_CLKS`;
  - inputs `aclk`, `areset`, `trigger`; output `pulse`;
  - instantiated twice, once for `start` and once for `channel`.
- A re-trigger while the stretcher's pulse is high restarts its width count. This cannot occur under legal parameters.

## Test plan
Bench parameters are N=4, P=8, START=2, CHANNEL=1 unless stated otherwise.
- Reset then `enable`=1 at edge E, `CHANNEL_TYPE`=1 → `start` high E..E+1 and `channel` high at E, E+8, E+16, E+24; `channel_index` reads 0, 1, 2, 3; `half`=1 from E+16.
- Same stimulus with `CHANNEL_TYPE`=0 → `channel` high at E+2, E+10, E+18, E+26; `start` unchanged.
- Hold `enable`=1 → `start` reasserts at E+32 with `channel_index`=0 and `busy` staying 1.
- `enable` dropped at E+5 → full sweep completes, then `busy`=0 after edge E+32, and no `start` at E+32.
- `areset` at E+13 → all outputs 0 after that edge; with `enable` still high, `start` resumes at E+14.
- With `MESSBAUER_SWEEP_COUNTER_EN`, 3 back-to-back sweeps → `sweep_done` pulses at E+31, E+63, E+95; `sweep_count` reads 3.
